// File: rtl/uart_tx_frame_ctrl.sv
// UART TX framing: start bit, DATA_WIDTH data bits LSB-first, optional parity, STOP_BITS stop bits.
// Parity is compiled in with `define UART_TX_PARITY_EN; requests are dropped while o_busy=1.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_tick,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_parity_odd,
  input  logic                  i_bit_overflow,
  output logic                  o_count_enable,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} state_t;
`endif

  state_t                state_q, state_n;
  logic [DATA_WIDTH-1:0] shift_q, shift_n;
  logic                  par_q, par_n;
  logic                  odd_q, odd_n;
  logic [1:0]            stop_cnt_q, stop_cnt_n;
  logic [3:0]            bit_cnt_q, bit_cnt_n;
  logic                  tx_n, busy_n, done_n, ce_n;
  logic                  last_bit;

  // A full 8-bit frame trusts the downstream counter; narrower frames count locally.
  assign last_bit = (DATA_WIDTH == 8) ? i_bit_overflow
                                      : (bit_cnt_q == 4'(DATA_WIDTH - 1));

`ifndef UART_TX_PARITY_EN
  logic unused_parity;
  assign unused_parity = &{1'b0, par_q, odd_q};
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      par_q          <= 1'b0;
      odd_q          <= 1'b0;
      stop_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      o_tx           <= 1'b1;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_count_enable <= 1'b0;
    end else begin
      state_q        <= state_n;
      shift_q        <= shift_n;
      par_q          <= par_n;
      odd_q          <= odd_n;
      stop_cnt_q     <= stop_cnt_n;
      bit_cnt_q      <= bit_cnt_n;
      o_tx           <= tx_n;
      o_busy         <= busy_n;
      o_done         <= done_n;
      o_count_enable <= ce_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    shift_n    = shift_q;
    par_n      = par_q;
    odd_n      = odd_q;
    stop_cnt_n = stop_cnt_q;
    bit_cnt_n  = bit_cnt_q;
    tx_n       = 1'b1;
    done_n     = 1'b0;
    ce_n       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_data_valid) begin
          shift_n    = i_data;
          odd_n      = i_parity_odd;
          par_n      = 1'b0;
          stop_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = ARM;
        end
      end
      // Waiting here for a fresh tick guarantees a full-length start bit.
      ARM: begin
        if (i_tick) begin
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (i_tick) begin
          state_n = DATA;
          tx_n    = shift_q[0];
        end
      end
      DATA: begin
        tx_n = shift_q[0];
        if (i_tick) begin
          ce_n      = 1'b1;
          shift_n   = shift_q >> 1;
          par_n     = par_q ^ shift_q[0];
          bit_cnt_n = bit_cnt_q + 4'd1;
          tx_n      = shift_n[0];
          if (last_bit) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q ^ shift_q[0] ^ odd_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_n = par_q ^ odd_q;
        if (i_tick) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (i_tick) begin
          if (stop_cnt_q != 2'(STOP_BITS - 1)) begin
            stop_cnt_n = stop_cnt_q + 2'd1;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench for uart_tx_frame_ctrl: instance a has 1 stop bit, instance b has 2 stop bits.
// The downstream bit counter is modelled per instance to drive i_bit_overflow.
module tb_uart_tx_frame_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam int P_EN = 1;
`else
  localparam int P_EN = 0;
`endif

  logic       CLK, RST, tick, odd, valid_a, valid_b;
  logic [7:0] data;
  logic       ovf_a, ovf_b, ce_a, ce_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [2:0] cnt_a, cnt_b;

  int tests_run = 0;
  int tests_failed = 0;
  int tick_per = 16;
  int tick_cnt = 0;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
    .CLK(CLK), .RST(RST), .i_tick(tick), .i_data(data), .i_data_valid(valid_a),
    .i_parity_odd(odd), .i_bit_overflow(ovf_a), .o_count_enable(ce_a),
    .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a));

  uart_tx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut_b (
    .CLK(CLK), .RST(RST), .i_tick(tick), .i_data(data), .i_data_valid(valid_b),
    .i_parity_odd(odd), .i_bit_overflow(ovf_b), .o_count_enable(ce_b),
    .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b));

  // Downstream 3-bit counter; overflow covers pulses already issued, including one in flight.
  always @(posedge CLK) begin
    if (RST) begin
      cnt_a <= 3'd0;
      cnt_b <= 3'd0;
    end else begin
      if (ce_a) cnt_a <= cnt_a + 3'd1;
      if (ce_b) cnt_b <= cnt_b + 3'd1;
    end
  end
  assign ovf_a = (({1'b0, cnt_a} + {3'b000, ce_a}) == 4'd7);
  assign ovf_b = (({1'b0, cnt_b} + {3'b000, ce_b}) == 4'd7);

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge CLK);
      if (tick_cnt >= tick_per - 1) begin
        tick = 1'b1;
        tick_cnt = 0;
      end else begin
        tick = 1'b0;
        tick_cnt++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "watchdog");
  end

  function automatic logic get_tx(input int w);   return (w == 0) ? tx_a   : tx_b;   endfunction
  function automatic logic get_ce(input int w);   return (w == 0) ? ce_a   : ce_b;   endfunction
  function automatic logic get_done(input int w); return (w == 0) ? done_a : done_b; endfunction
  function automatic logic get_busy(input int w); return (w == 0) ? busy_a : busy_b; endfunction

  logic cap_bits [0:15];
  bit   cap_stable [0:15];
  bit   cap_fall;
  int   cap_wait, cap_ce, cap_done_in, cap_busy_low;
  logic cap_done_end, cap_busy_end;
  logic exp_bits [0:15];
  int   exp_n;

  task automatic build_exp(input logic [7:0] d, input logic par_odd, input int nstop);
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
    exp_n = 9;
    if (P_EN == 1) begin
      exp_bits[9] = (^d) ^ par_odd;
      exp_n = 10;
    end
    for (int i = 0; i < nstop; i++) exp_bits[exp_n + i] = 1'b1;
    exp_n = exp_n + nstop;
  endtask

  // Records one frame: waits for the start edge, then samples nbits*per cycles plus the done cycle.
  task automatic capture(input int w, input int nbits, input int per);
    logic tx;
    cap_fall = 0; cap_wait = 0; cap_ce = 0; cap_done_in = 0; cap_busy_low = 0;
    cap_done_end = 1'b0; cap_busy_end = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cap_bits[i] = 1'bx;
      cap_stable[i] = 1;
    end
    for (int i = 0; i < 400 && !cap_fall; i++) begin
      @(negedge CLK);
      if (get_tx(w) === 1'b0) cap_fall = 1;
      else cap_wait++;
    end
    if (cap_fall) begin
      for (int s = 0; s <= nbits * per; s++) begin
        if (s > 0) @(negedge CLK);
        tx = get_tx(w);
        if (get_ce(w) === 1'b1) cap_ce++;
        if (s < nbits * per) begin
          if (s % per == 0) cap_bits[s / per] = tx;
          else if (tx !== cap_bits[s / per]) cap_stable[s / per] = 0;
          if (get_done(w) !== 1'b0) cap_done_in++;
          if (get_busy(w) !== 1'b1) cap_busy_low++;
        end else begin
          cap_done_end = get_done(w);
          cap_busy_end = get_busy(w);
        end
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; valid_a = 1'b0; valid_b = 1'b0; data = 8'h00; odd = 1'b0;
    repeat (2) @(negedge CLK);
    tests_run++; if (tx_a !== 1'b1)   begin tests_failed++; $display("FAIL reset_tx_a: got %b want 1", tx_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    tests_run++; if (done_a !== 1'b0) begin tests_failed++; $display("FAIL reset_done_a: got %b want 0", done_a); end
    tests_run++; if (ce_a !== 1'b0)   begin tests_failed++; $display("FAIL reset_ce_a: got %b want 0", ce_a); end
    tests_run++; if (tx_b !== 1'b1)   begin tests_failed++; $display("FAIL reset_tx_b: got %b want 1", tx_b); end
    tests_run++; if (busy_b !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic_frame;
    int n;
    n = 10 + P_EN;
    tick_per = 16;
    data = 8'hA5; odd = 1'b0; valid_a = 1'b1;
    @(negedge CLK);
    valid_a = 1'b0;
    tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_after_accept: got %b want 1", busy_a); end
    build_exp(8'hA5, 1'b0, 1);
    capture(0, n, 16);
    tests_run++; if (cap_fall !== 1'b1) begin tests_failed++; $display("FAIL basic_start_edge: none within 400 cycles"); end
    for (int b = 0; b < exp_n; b++) begin
      tests_run++;
      if (cap_bits[b] !== exp_bits[b] || !cap_stable[b]) begin
        tests_failed++;
        $display("FAIL basic_bit%0d: got %b (held=%0d) want %b held 16 cycles", b, cap_bits[b], cap_stable[b], exp_bits[b]);
      end
    end
    tests_run++; if (cap_ce != 8) begin tests_failed++; $display("FAIL basic_count_enable: got %0d pulses want 8", cap_ce); end
    tests_run++; if (cap_done_in != 0 || cap_done_end !== 1'b1) begin
      tests_failed++; $display("FAIL basic_done: early=%0d at_end=%b want 0 and 1", cap_done_in, cap_done_end); end
    tests_run++; if (cap_busy_low != 0 || cap_busy_end !== 1'b0) begin
      tests_failed++; $display("FAIL basic_busy: low_in_frame=%0d at_done=%b want 0 and 0", cap_busy_low, cap_busy_end); end
    @(negedge CLK);
    tests_run++; if (done_a !== 1'b0) begin tests_failed++; $display("FAIL basic_done_width: got %b one cycle later want 0", done_a); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    tick_per = 4;
    for (int k = 0; k < 2; k++) begin
      data = 8'h07; odd = (k == 1); valid_a = 1'b1;
      @(negedge CLK);
      valid_a = 1'b0;
      capture(0, 11, 4);
      tests_run++;
      if (cap_bits[9] !== ((k == 0) ? 1'b1 : 1'b0) || !cap_stable[9]) begin
        tests_failed++; $display("FAIL parity_bit_odd%0d: got %b want %b", k, cap_bits[9], (k == 0) ? 1'b1 : 1'b0);
      end
      tests_run++;
      if (cap_done_in != 0 || cap_done_end !== 1'b1) begin
        tests_failed++; $display("FAIL parity_len_odd%0d: early_done=%0d done_at_11=%b want 0 and 1", k, cap_done_in, cap_done_end);
      end
    end
  endtask
`endif

  task automatic test_busy_reject;
    int  n;
    bit  quiet;
    n = 10 + P_EN;
    tick_per = 8;
    data = 8'h96; odd = 1'b0; valid_a = 1'b1;
    @(negedge CLK);
    valid_a = 1'b0;
    build_exp(8'h96, 1'b0, 1);
    fork
      capture(0, n, 8);
      begin
        repeat (30) @(negedge CLK);
        data = 8'h3C; odd = 1'b1; valid_a = 1'b1;
        @(negedge CLK);
        valid_a = 1'b0;
      end
    join
    for (int b = 0; b < exp_n; b++) begin
      tests_run++;
      if (cap_bits[b] !== exp_bits[b] || !cap_stable[b]) begin
        tests_failed++; $display("FAIL reject_bit%0d: got %b (held=%0d) want %b", b, cap_bits[b], cap_stable[b], exp_bits[b]);
      end
    end
    tests_run++; if (cap_busy_low != 0 || cap_done_end !== 1'b1) begin
      tests_failed++; $display("FAIL reject_busy: low_in_frame=%0d done_at_end=%b want 0 and 1", cap_busy_low, cap_done_end); end
    quiet = 1;
    repeat (24) begin
      @(negedge CLK);
      if (busy_a !== 1'b0 || tx_a !== 1'b1) quiet = 0;
    end
    tests_run++; if (!quiet) begin tests_failed++; $display("FAIL reject_no_queue: line/busy active after done, want idle"); end
  endtask

  task automatic test_back_to_back;
    int n;
    n = 11 + P_EN;
    tick_per = 8;
    data = 8'h55; odd = 1'b0; valid_b = 1'b1;
    fork
      begin
        build_exp(8'h55, 1'b0, 2);
        capture(1, n, 8);
        tests_run++; if (cap_fall !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_start: none within 400 cycles"); end
        for (int b = 0; b < exp_n; b++) begin
          tests_run++;
          if (cap_bits[b] !== exp_bits[b] || !cap_stable[b]) begin
            tests_failed++; $display("FAIL b2b_f1_bit%0d: got %b want %b", b, cap_bits[b], exp_bits[b]);
          end
        end
        tests_run++; if (cap_done_end !== 1'b1 || cap_done_in != 0) begin
          tests_failed++; $display("FAIL b2b_f1_done: at_end=%b early=%0d want 1 and 0", cap_done_end, cap_done_in); end
        build_exp(8'hAA, 1'b0, 2);
        capture(1, n, 8);
        tests_run++; if (cap_wait != 7) begin
          tests_failed++; $display("FAIL b2b_gap: got %0d idle cycles before start want 7", cap_wait); end
        for (int b = 0; b < exp_n; b++) begin
          tests_run++;
          if (cap_bits[b] !== exp_bits[b] || !cap_stable[b]) begin
            tests_failed++; $display("FAIL b2b_f2_bit%0d: got %b want %b", b, cap_bits[b], exp_bits[b]);
          end
        end
        tests_run++; if (cap_done_end !== 1'b1 || cap_done_in != 0) begin
          tests_failed++; $display("FAIL b2b_f2_done: at_end=%b early=%0d want 1 and 0", cap_done_end, cap_done_in); end
      end
      begin
        for (int i = 0; i < 20 && busy_b !== 1'b1; i++) @(negedge CLK);
        data = 8'hAA;
        for (int i = 0; i < 400 && done_b !== 1'b1; i++) @(negedge CLK);
        @(negedge CLK);
        valid_b = 1'b0;
      end
    join
  endtask

  task automatic test_reset_mid_frame;
    bit fell;
    int n;
    n = 10 + P_EN;
    tick_per = 8;
    data = 8'hF0; odd = 1'b0; valid_a = 1'b1;
    @(negedge CLK);
    valid_a = 1'b0;
    fell = 0;
    for (int i = 0; i < 400 && !fell; i++) begin
      @(negedge CLK);
      if (tx_a === 1'b0) fell = 1;
    end
    tests_run++; if (!fell) begin tests_failed++; $display("FAIL midrst_start: none within 400 cycles"); end
    repeat (34) @(negedge CLK);
    tests_run++; if (tx_a !== 1'b0) begin tests_failed++; $display("FAIL midrst_bit3: got %b want 0", tx_a); end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    tests_run++; if (tx_a !== 1'b1)   begin tests_failed++; $display("FAIL midrst_tx: got %b want 1", tx_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b want 0", busy_a); end
    @(negedge CLK);
    data = 8'hC3; odd = 1'b0; valid_a = 1'b1;
    @(negedge CLK);
    valid_a = 1'b0;
    build_exp(8'hC3, 1'b0, 1);
    capture(0, n, 8);
    for (int b = 0; b < exp_n; b++) begin
      tests_run++;
      if (cap_bits[b] !== exp_bits[b] || !cap_stable[b]) begin
        tests_failed++; $display("FAIL midrst_new_bit%0d: got %b want %b", b, cap_bits[b], exp_bits[b]);
      end
    end
    tests_run++; if (cap_ce != 8 || cap_done_end !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_new_frame: ce=%0d done=%b want 8 and 1", cap_ce, cap_done_end); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
